// File: rtl/pool_scheduler.sv
// pool_scheduler: 2x2 stride-2 max-pooling read/write sequencer.
// Fetches each window's four pixels through a 1-cycle-latency read port,
// keeps a signed running maximum and writes one pooled result per window
// through a ready-qualified write port.
// Optional build macro: POOL_RELU_EN -- clamps each pooled result at zero
// (fused ReLU); timing is the same with and without it.
module pool_scheduler #(
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int DW    = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p_load,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ready,
    output logic          done_p,
    output logic          busy
);

    // Window grid; an odd trailing row/column simply falls outside it.
    localparam int WIN_X = MAP_W / 2;
    localparam int WIN_Y = MAP_H / 2;
    localparam int CW    = (WIN_X > 1) ? $clog2(WIN_X) : 1;
    localparam int RW    = (WIN_Y > 1) ? $clog2(WIN_Y) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIN_X - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(WIN_Y - 1);

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE, HOLD
    } state_t;

    state_t               r_state;
    logic [RW-1:0]        r_row;
    logic [CW-1:0]        r_col;
    logic [AW-1:0]        r_out_idx;
    logic signed [DW-1:0] r_acc;
    logic                 r_rd_req;
    logic [AW-1:0]        r_rd_addr;
    logic                 r_wr_en;
    logic [DW-1:0]        r_wr_data;
    logic                 r_done_p;

    logic                 w_last_col;
    logic                 w_last_win;
    logic [CW-1:0]        w_col_nxt;
    logic [RW-1:0]        w_row_nxt;
    logic [AW-1:0]        w_base;
    logic [AW-1:0]        w_base_nxt;
    logic signed [DW-1:0] w_rd_s;
    logic signed [DW-1:0] w_max;
    logic signed [DW-1:0] w_result;

    // Top-left pixel address of window (row, col): 2*row*MAP_W + 2*col.
    function automatic logic [AW-1:0] win_base(input logic [RW-1:0] row,
                                               input logic [CW-1:0] col);
        int addr;
        addr = 2 * int'(row) * MAP_W + 2 * int'(col);
        return AW'(addr);
    endfunction

    // Raster-order window stepping: column first, wrap into the next row.
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_win = w_last_col && (r_row == ROW_LAST);
    assign w_col_nxt  = w_last_col ? '0 : r_col + CW'(1);
    assign w_row_nxt  = w_last_col ? r_row + RW'(1) : r_row;
    assign w_base     = win_base(r_row, r_col);
    assign w_base_nxt = win_base(w_row_nxt, w_col_nxt);

    // Signed running max; strict greater-than keeps the earlier value on a tie.
    assign w_rd_s = $signed(rd_data);
    assign w_max  = (w_rd_s > r_acc) ? w_rd_s : r_acc;

    // Value presented on the write port.
`ifdef POOL_RELU_EN
    assign w_result = w_max[DW-1] ? '0 : w_max;
`else
    assign w_result = w_max;
`endif

    // All handshake outputs come straight from registers.
    assign rd_req  = r_rd_req;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_out_idx;
    assign wr_data = r_wr_data;
    assign done_p  = r_done_p;
    assign busy    = (r_state != IDLE);

    // Sequencer FSM with registered strobes; dropping p_load mid-run aborts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_out_idx <= '0;
            r_acc     <= '0;
            r_rd_req  <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_done_p  <= 1'b0;
        end else begin
            r_rd_req <= 1'b0;
            r_wr_en  <= 1'b0;
            r_done_p <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (p_load) begin
                        r_state   <= RD0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_out_idx <= '0;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                RD0: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= RD1;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_base + AW'(1);
                    end
                end
                RD1: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= RD2;
                        r_acc     <= w_rd_s;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_base + AW'(MAP_W);
                    end
                end
                RD2: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= RD3;
                        r_acc     <= w_max;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_base + AW'(MAP_W + 1);
                    end
                end
                RD3: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= CAP;
                        r_acc   <= w_max;
                    end
                end
                CAP: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= WR;
                        r_acc     <= w_max;
                        r_wr_data <= w_result;
                        r_wr_en   <= 1'b1;
                    end
                end
                WR: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end else if (wr_ready) begin
                        if (w_last_win) begin
                            r_state  <= DONE;
                            r_done_p <= 1'b1;
                        end else begin
                            r_state   <= RD0;
                            r_row     <= w_row_nxt;
                            r_col     <= w_col_nxt;
                            r_out_idx <= r_out_idx + AW'(1);
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= w_base_nxt;
                        end
                    end else begin
                        r_wr_en <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (!p_load) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_scheduler.sv
// tb_pool_scheduler: directed + randomized check of pool_scheduler on a
// 4x4 map against a window-by-window max-pooling reference model.
module tb_pool_scheduler;

    localparam int MW   = 4;
    localparam int MH   = 4;
    localparam int DW   = 8;
    localparam int AW   = 6;
    localparam int NWIN = (MW / 2) * (MH / 2);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p_load;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          done_p;
    logic          busy;

    logic [DW-1:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    // monitor state (written only by the monitor process)
    int            mon_rd = 0, mon_wr = 0, mon_done = 0;
    int            mon_ovl = 0, mon_stall = 0, mon_unstable = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] wq_addr [$];
    logic [DW-1:0] wq_data [$];

    // snapshots taken by the stimulus process
    int s_rd, s_wr, s_done, s_ovl, s_stall, s_unstable, s_wq;

    pool_scheduler #(.MAP_W(MW), .MAP_H(MH), .DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .p_load   (p_load),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .done_p   (done_p),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // feature-map memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (rd_req) rd_data <= mem[rd_addr];
    end

    // mid-cycle bus monitor
    always @(negedge clk) begin
        if (rd_req) mon_rd <= mon_rd + 1;
        if (wr_en) mon_wr <= mon_wr + 1;
        if (done_p) mon_done <= mon_done + 1;
        if (rd_req && wr_en) mon_ovl <= mon_ovl + 1;
        if (wr_en && !wr_ready) mon_stall <= mon_stall + 1;
        if (prev_stall && !(wr_en && wr_addr == prev_addr && wr_data == prev_data))
            mon_unstable <= mon_unstable + 1;
        if (wr_en && wr_ready) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        prev_stall <= wr_en && !wr_ready;
        prev_addr  <= wr_addr;
        prev_data  <= wr_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // reference: max of each 2x2 window in raster order
    function automatic logic [DW-1:0] exp_pool(input int w);
        int row, col, best, v;
        row  = w / (MW / 2);
        col  = w % (MW / 2);
        best = $signed(mem[2 * row * MW + 2 * col]);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = $signed(mem[(2 * row + dy) * MW + 2 * col + dx]);
                if (v > best) best = v;
            end
`ifdef POOL_RELU_EN
        if (best < 0) best = 0;
`endif
        return best[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rd = mon_rd; s_wr = mon_wr; s_done = mon_done; s_ovl = mon_ovl;
        s_stall = mon_stall; s_unstable = mon_unstable; s_wq = wq_addr.size();
    endtask

    task automatic check_writes(input string tag);
        int n;
        n = wq_addr.size() - s_wq;
        check({tag, "_wr_count"}, n, NWIN);
        for (int i = 0; i < NWIN && i < n; i++) begin
            $display("%s write %0d addr=%0d data=%0d", tag, i, wq_addr[s_wq + i], $signed(wq_data[s_wq + i]));
            check($sformatf("%s_wr_addr%0d", tag, i), 32'(wq_addr[s_wq + i]), i);
            check($sformatf("%s_wr_data%0d", tag, i), 32'(wq_data[s_wq + i]), 32'(exp_pool(i)));
        end
    endtask

    // mode 0: wr_ready high; 1: random wr_ready; 2: 5-cycle stall on 2nd write
    task automatic run_pool(input int mode, output int lat);
        int budget;
        bit ok;
        budget = 5;
        ok = 1'b0;
        lat = 0;
        wr_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        p_load = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick();
            lat++;
            if (done_p) begin
                ok = 1'b1;
                break;
            end
            if (mode == 1) wr_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && wr_en && wr_addr == AW'(1) && budget > 0) begin
                wr_ready = 1'b0;
                budget--;
            end else wr_ready = 1'b1;
        end
        wr_ready = 1'b1;
        check("done_seen", 32'(ok), 1);
    endtask

    task automatic end_pool(input string tag);
        tick();
        check({tag, "_done_width"}, 32'(done_p), 0);
        p_load = 1'b0;
        tick();
        check({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_req"}, 32'(rd_req), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_done_p"}, 32'(done_p), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int lat;
        int k;
        logic [DW-1:0] exp033 [0:3];
        logic [DW-1:0] exp034;
        exp033[0] = 8'd5; exp033[1] = 8'd7; exp033[2] = 8'd13; exp033[3] = 8'd15;
`ifdef POOL_RELU_EN
        exp034 = 8'd0;
`else
        exp034 = 8'hFF;
`endif
        reset_n  = 1'b0;
        p_load   = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // reset state
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        snap();
        repeat (4) tick();
        check("no_start_busy", 32'(busy), 0);
        check("no_start_reads", mon_rd - s_rd, 0);

        // 0..15 map, ready tied high, p_load held through HOLD
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        snap();
        run_pool(0, lat);
        $display("ramp map: done_p after %0d cycles", lat);
        check("ramp_latency", lat, 25);
        tick();
        check("ramp_done_width", 32'(done_p), 0);
        repeat (19) tick();
        check("hold_single_done", mon_done - s_done, 1);
        check("hold_busy", 32'(busy), 1);
        check("hold_reads", mon_rd - s_rd, 16);
        check("ramp_overlap", mon_ovl - s_ovl, 0);
        check_writes("ramp");
        for (int i = 0; i < NWIN && (s_wq + i) < wq_data.size(); i++)
            check($sformatf("ramp_const%0d", i), 32'(wq_data[s_wq + i]), 32'(exp033[i]));
        p_load = 1'b0;
        tick();
        check("hold_release_busy", 32'(busy), 0);

        // randomized maps with random write back-pressure
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
            snap();
            run_pool(1, lat);
            $display("random run %0d: latency=%0d stalls=%0d", t, lat, mon_stall - s_stall);
            check($sformatf("rand%0d_latency", t), lat, 25 + (mon_stall - s_stall));
            check($sformatf("rand%0d_unstable", t), mon_unstable - s_unstable, 0);
            check($sformatf("rand%0d_overlap", t), mon_ovl - s_ovl, 0);
            end_pool($sformatf("rand%0d", t));
            check_writes($sformatf("rand%0d", t));
        end

        // all-negative first window
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        mem[0] = -8'sd3; mem[1] = -8'sd7; mem[MW] = -8'sd1; mem[MW + 1] = -8'sd9;
        snap();
        run_pool(0, lat);
        end_pool("neg");
        check_writes("neg");
        if (wq_data.size() > s_wq) check("neg_window_value", 32'(wq_data[s_wq]), 32'(exp034));
        else check("neg_window_present", wq_data.size(), s_wq + 1);

        // 5-cycle stall on the second write
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        snap();
        run_pool(2, lat);
        $display("stall run: latency=%0d wr_en cycles=%0d", lat, mon_wr - s_wr);
        check("stall_latency", lat, 30);
        check("stall_wr_cycles", mon_wr - s_wr, NWIN + 5);
        check("stall_count", mon_stall - s_stall, 5);
        check("stall_unstable", mon_unstable - s_unstable, 0);
        end_pool("stall");
        check_writes("stall");

        // abort during RD2 of window 1
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        snap();
        p_load = 1'b1;
        repeat (9) tick();
        check("abort_rd2_req", 32'(rd_req), 1);
        check("abort_rd2_addr", 32'(rd_addr), 2 + MW);
        p_load = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_rd_req", 32'(rd_req), 0);
        check("abort_wr_en", 32'(wr_en), 0);
        repeat (10) tick();
        check("abort_no_done", mon_done - s_done, 0);
        check("abort_reads", mon_rd - s_rd, 7);
        check("abort_writes", wq_addr.size() - s_wq, 1);
        snap();
        run_pool(0, lat);
        check("restart_latency", lat, 25);
        end_pool("restart");
        check_writes("restart");

        // asynchronous reset while the second write is pending
        for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
        snap();
        p_load = 1'b1;
        k = 0;
        while (!(wr_en && wr_addr == AW'(1)) && k < 50) begin
            tick();
            k++;
        end
        check("reset_wr_reached", 32'(wr_en && wr_addr == AW'(1)), 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        p_load = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("reset_no_done", mon_done - s_done, 0);
        check("reset_busy_after", 32'(busy), 0);
        check("reset_writes", wq_addr.size() - s_wq, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_scheduler.md
POOL_SCHEDULER -- requirements
Module: pool_scheduler

Interface
REQ-001 SHALL have parameter MAP_W, default 8, input feature-map width in pixels.
REQ-002 SHALL have parameter MAP_H, default 8, input feature-map height in pixels.
REQ-003 SHALL have parameter DW, default 8, signed pixel width.
REQ-004 SHALL have parameter AW, default 6, read and write address width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port p_load  input  1  level start from the layer controller, held high during the pooling phase.
REQ-008 SHALL have port rd_req  output  1  feature-map read strobe.
REQ-009 SHALL have port rd_addr  output  AW  feature-map read address.
REQ-010 SHALL have port rd_data  input  DW  signed read data, valid exactly 1 cycle after rd_req.
REQ-011 SHALL have port wr_en  output  1  pooled-result write request.
REQ-012 SHALL have port wr_addr  output  AW  pooled-result index.
REQ-013 SHALL have port wr_data  output  DW  pooled result.
REQ-014 SHALL have port wr_ready  input  1  sink accepts the write when high with wr_en.
REQ-015 SHALL have port done_p  output  1  one-cycle completion pulse.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement 2x2, stride-2 max pooling; windows = (MAP_H/2)*(MAP_W/2), integer division; an odd trailing row or column is ignored.
REQ-018 SHALL use FSM states IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE, HOLD.
REQ-019 IDLE->RD0 when p_load=1; window row r=0, col c=0, out index=0.
REQ-020 RDk (k=0..3) SHALL assert rd_req for one cycle with rd_addr = base, base+1, base+MAP_W, base+MAP_W+1 in order; base = 2r*MAP_W + 2c.
REQ-021 Max accumulator SHALL load rd_data in the cycle after RD0 and signed-compare-update in the cycles after RD1..RD3; on a tie the earlier value is kept.
REQ-022 CAP SHALL absorb the RD3 data; CAP->WR unconditionally.
REQ-023 WR SHALL hold wr_en=1 with stable wr_addr and wr_data until wr_ready=1; the transfer completes in that cycle.
REQ-024 After a completed write: if this was the last window, go to DONE; otherwise advance c, wrap c to 0 and increment r at MAP_W/2, increment the out index, and go to RD0.
REQ-025 Throughput with wr_ready tied high: 6 cycles per window; 8x8 map = 96 cycles from RD0 entry to DONE entry.
REQ-026 DONE SHALL assert done_p for exactly one cycle, then go to HOLD.
REQ-027 HOLD->IDLE only when p_load=0, so a level p_load never retriggers.
REQ-028 p_load=0 in any of RD0..WR SHALL abort to IDLE next cycle; no done_p, no further rd_req or wr_en.
REQ-029 rd_req, wr_en and done_p SHALL be registered outputs; rd_req and wr_en never assert in the same cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state IDLE and r, c, out index, accumulator and all outputs to 0, including mid-window and mid-WR.
REQ-031 After reset release, operation SHALL start only on p_load=1 sampled in IDLE.

Configuration
REQ-032 When POOL_RELU_EN is defined, wr_data SHALL be max(window max, 0), fusing ReLU; when undefined, wr_data is the raw signed window max; timing is identical in both builds.

Verification
REQ-033 4x4 map of 0..15, wr_ready=1, p_load held -> writes (0,5),(1,7),(2,13),(3,15) and done_p pulses 25 cycles after p_load rises.
REQ-034 Window {-3,-7,-1,-9}, MAP_W=MAP_H=2 -> wr_data=-1 without POOL_RELU_EN and 0 with POOL_RELU_EN.
REQ-035 wr_ready low for 5 cycles on the 2nd write -> wr_en held 6 cycles with stable addr/data; total time grows by 5 cycles.
REQ-036 p_load dropped during RD2 of window 1 -> IDLE next cycle, no done_p, no further strobes; a new p_load restarts at out index 0.
REQ-037 reset_n pulsed low during WR -> all outputs 0 immediately; busy=0; no done_p.
REQ-038 p_load held high 20 cycles after done_p -> single done_p, FSM stays in HOLD, no new reads.
